// File: rtl/irq_pend_ctrl.sv
// rtl/irq_pend_ctrl.sv - four-line interrupt pending front end with valid/ack code presentation
module irq_pend_ctrl #(
  parameter int GAP_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] mask,
  input  logic       ack,
  output logic [3:0] pend,
  output logic       irq_valid,
  output logic [1:0] irq_code,
  output logic [3:0] overrun
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    GAP     = 2'd2
  } state_t;

  localparam logic [1:0] GAP_LOAD = 2'(GAP_CYCLES - 1);

  state_t     state, state_next;
  logic [3:0] req_q;
  logic [3:0] rise;
  logic [3:0] clr;
  logic [3:0] elig;
  logic [1:0] winner;
  logic [1:0] gap_cnt, gap_next;
  logic [1:0] code_next;
  logic       valid_next;

  assign rise = req & ~req_q;
  assign clr  = (state == PRESENT && ack) ? (4'b0001 << irq_code) : 4'b0000;
  assign elig = pend & ~mask;

  always_comb begin
    winner = 2'd0;
    if (elig[3])      winner = 2'd3;
    else if (elig[2]) winner = 2'd2;
    else if (elig[1]) winner = 2'd1;
  end

  // The code is latched on entry to PRESENT and held until ack, regardless of pend/mask changes.
  always_comb begin
    state_next = state;
    gap_next   = gap_cnt;
    code_next  = irq_code;
    valid_next = irq_valid;
    case (state)
      IDLE: begin
        if (elig != 4'b0000) begin
          state_next = PRESENT;
          code_next  = winner;
          valid_next = 1'b1;
        end
      end
      PRESENT: begin
        if (ack) begin
          state_next = GAP;
          gap_next   = GAP_LOAD;
          code_next  = 2'd0;
          valid_next = 1'b0;
        end
      end
      GAP: begin
        if (gap_cnt != 2'd0) begin
          gap_next = gap_cnt - 2'd1;
        end else if (elig != 4'b0000) begin
          state_next = PRESENT;
          code_next  = winner;
          valid_next = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        gap_next   = 2'd0;
        code_next  = 2'd0;
        valid_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gap_cnt   <= 2'd0;
      irq_code  <= 2'd0;
      irq_valid <= 1'b0;
      req_q     <= 4'b0000;
      pend      <= 4'b0000;
      overrun   <= 4'b0000;
    end else begin
      state     <= state_next;
      gap_cnt   <= gap_next;
      irq_code  <= code_next;
      irq_valid <= valid_next;
      req_q     <= req;
      // A rise landing on the bit being acked wins, and does not count as an overrun.
      pend      <= (pend & ~clr) | rise;
      overrun   <= overrun | (rise & pend & ~clr);
    end
  end

endmodule

// File: tb/tb_irq_pend_ctrl.sv
// tb/tb_irq_pend_ctrl.sv - scoreboard bench for irq_pend_ctrl
module tb_irq_pend_ctrl;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] mask;
  logic       ack;
  logic [3:0] pend;
  logic       irq_valid;
  logic [1:0] irq_code;
  logic [3:0] overrun;

  int n_checks = 0;
  int n_errors = 0;
  int exp_q[$];

  irq_pend_ctrl #(.GAP_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .req(req), .mask(mask), .ack(ack),
    .pend(pend), .irq_valid(irq_valid), .irq_code(irq_code), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int pop_exp();
    if (exp_q.size() == 0) return -1;
    return exp_q.pop_front();
  endfunction

  task automatic do_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0000;
    mask = 4'b0000;
    ack = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic check_present(input string name);
    int e;
    e = pop_exp();
    n_checks++;
    if (irq_valid !== 1'b1) begin n_errors++; $display("FAIL %s_valid: got %b want 1", name, irq_valid); end
    n_checks++;
    if ({30'd0, irq_code} !== e) begin n_errors++; $display("FAIL %s_code: got %0d want %0d", name, irq_code, e); end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b0100; mask = 4'b0000; ack = 1'b0;
    tick(); tick();
    n_checks++;
    if ({pend, irq_valid, irq_code, overrun} !== 11'd0) begin
      n_errors++;
      $display("FAIL reset_state: got pend=%b valid=%b code=%0d ovr=%b want all 0", pend, irq_valid, irq_code, overrun);
    end
    rst = 1'b0;
    exp_q.push_back(2);
    tick();
    n_checks++;
    if (pend !== 4'b0100 || irq_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL first_capture: got pend=%b valid=%b want 0100/0", pend, irq_valid);
    end
    tick();
    check_present("reset_present");
    do_ack();
    n_checks++;
    if (pend !== 4'b0000 || irq_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_ack: got pend=%b valid=%b want 0000/0", pend, irq_valid);
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_priority();
    req = 4'b1011;
    tick();
    req = 4'b0000;
    exp_q.push_back(3); exp_q.push_back(1); exp_q.push_back(0);
    n_checks++;
    if (pend !== 4'b1011 || irq_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL prio_capture: got pend=%b valid=%b want 1011/0", pend, irq_valid);
    end
    tick();
    for (int k = 0; k < 3; k++) begin
      check_present("prio");
      do_ack();
      n_checks++;
      if (irq_valid !== 1'b0) begin n_errors++; $display("FAIL prio_gap%0d: got valid=%b want 0", k, irq_valid); end
      tick();
    end
    n_checks++;
    if (pend !== 4'b0000 || irq_valid !== 1'b0 || irq_code !== 2'd0) begin
      n_errors++;
      $display("FAIL prio_idle: got pend=%b valid=%b code=%0d want 0000/0/0", pend, irq_valid, irq_code);
    end
  endtask

  task automatic test_frozen();
    req = 4'b0010;
    tick();
    req = 4'b0000;
    exp_q.push_back(1); exp_q.push_back(3);
    tick();
    req = 4'b1000;
    tick();
    req = 4'b0000;
    tick(); tick();
    n_checks++;
    if (pend !== 4'b1010) begin n_errors++; $display("FAIL frozen_pend: got %b want 1010", pend); end
    check_present("frozen_hold");
    do_ack();
    n_checks++;
    if (irq_valid !== 1'b0) begin n_errors++; $display("FAIL frozen_gap: got valid=%b want 0", irq_valid); end
    tick();
    check_present("frozen_next");
    do_ack();
    tick();
  endtask

  task automatic test_mask();
    mask = 4'b1000;
    req = 4'b1000;
    tick();
    req = 4'b0000;
    tick(); tick();
    n_checks++;
    if (pend !== 4'b1000 || irq_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL mask_block: got pend=%b valid=%b want 1000/0", pend, irq_valid);
    end
    mask = 4'b0000;
    exp_q.push_back(3);
    tick();
    check_present("mask_release");
    do_ack();
    tick();
  endtask

  task automatic test_set_wins();
    do_reset();
    req = 4'b0100;
    tick();
    req = 4'b0000;
    exp_q.push_back(2); exp_q.push_back(2);
    tick();
    check_present("setwins_first");
    req = 4'b0100;
    ack = 1'b1;
    tick();
    req = 4'b0000;
    ack = 1'b0;
    n_checks++;
    if (pend !== 4'b0100 || irq_valid !== 1'b0 || overrun !== 4'b0000) begin
      n_errors++;
      $display("FAIL setwins_state: got pend=%b valid=%b ovr=%b want 0100/0/0000", pend, irq_valid, overrun);
    end
    tick();
    check_present("setwins_again");
    do_ack();
    tick();
  endtask

  task automatic test_overrun();
    req = 4'b0100;
    tick();
    req = 4'b0000;
    tick();
    req = 4'b0100;
    tick();
    req = 4'b0000;
    exp_q.push_back(2);
    n_checks++;
    if (overrun !== 4'b0100 || pend !== 4'b0100) begin
      n_errors++;
      $display("FAIL overrun_set: got ovr=%b pend=%b want 0100/0100", overrun, pend);
    end
    check_present("overrun_code");
    do_ack();
    tick();
  endtask

  task automatic test_spurious_ack();
    mask = 4'b0001;
    req = 4'b0001;
    tick();
    req = 4'b0000;
    tick();
    ack = 1'b1;
    tick(); tick();
    ack = 1'b0;
    n_checks++;
    if (pend !== 4'b0001 || irq_valid !== 1'b0 || irq_code !== 2'd0 || overrun !== 4'b0100) begin
      n_errors++;
      $display("FAIL spurious_ack: got pend=%b valid=%b code=%0d ovr=%b want 0001/0/0/0100", pend, irq_valid, irq_code, overrun);
    end
    mask = 4'b0000;
    exp_q.push_back(0);
    tick();
    check_present("spurious_after");
    do_ack();
    tick();
  endtask

  task automatic test_async_reset();
    req = 4'b1000;
    tick();
    req = 4'b0000;
    exp_q.push_back(3);
    tick();
    check_present("async_pre");
    #3;
    rst = 1'b1;
    #1;
    n_checks++;
    if (irq_valid !== 1'b0 || pend !== 4'b0000 || overrun !== 4'b0000 || irq_code !== 2'd0) begin
      n_errors++;
      $display("FAIL async_reset: got valid=%b pend=%b ovr=%b code=%0d want 0/0000/0000/0", irq_valid, pend, overrun, irq_code);
    end
    tick();
    rst = 1'b0;
    tick();
    n_checks++;
    if (irq_valid !== 1'b0) begin n_errors++; $display("FAIL async_after: got valid=%b want 0", irq_valid); end
  endtask

  initial begin
    rst = 1'b1; req = 4'b0000; mask = 4'b0000; ack = 1'b0;
    test_reset();
    test_priority();
    test_frozen();
    test_mask();
    test_set_wins();
    test_overrun();
    test_spurious_ack();
    test_async_reset();
    n_checks++;
    if (exp_q.size() != 0) begin n_errors++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
